oa222_stim_checker: RTL and testbench

OA222_STIM_CHECKER -- requirements
Module: oa222_stim_checker

---
 rtl/oa222_stim_checker_if.sv | 22 ++
 rtl/oa222_stim_checker.sv | 134 +++++++++++++
 tb/tb_oa222_stim_checker.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/oa222_stim_checker_if.sv
// Signal bundle between the OA222 stimulus checker and its environment.
// The checker uses the slave view. The environment and the bench use the master view.
interface oa222_stim_checker_if;
    logic        START;
    logic        DUT_Q;
    logic [5:0]  STIM;
    logic        BUSY;
    logic        DONE;
    logic        PASS;
    logic [15:0] ERR_CNT;
    logic [15:0] TOG_CNT;

    modport slave (
        input  START, DUT_Q,
        output STIM, BUSY, DONE, PASS, ERR_CNT, TOG_CNT
    );

    modport master (
        output START, DUT_Q,
        input  STIM, BUSY, DONE, PASS, ERR_CNT, TOG_CNT
    );
endinterface

// File: rtl/oa222_stim_checker.sv
// Drives an OA222 cell with an x^6+x^5+1 LFSR sequence and compares its Q against a golden value.
// It counts mismatches and output toggles, and reports the result with a one-cycle DONE pulse.
module oa222_stim_checker #(
    parameter int unsigned N_VEC = 256,
    parameter int unsigned LAT   = 1,
    parameter logic [5:0]  SEED  = 6'h2D
) (
    input logic                  CLK,
    input logic                  RSTB,
    oa222_stim_checker_if.slave  bus
);
    // An all-zero seed would lock the LFSR, so it is replaced by 6'h01.
    localparam logic [5:0]  SEED_EFF = (SEED == 6'h00) ? 6'h01 : SEED;
    localparam logic [15:0] N_VEC_W  = 16'(N_VEC);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [5:0]      stim_q, stim_d;
    logic [15:0]     issued_q, issued_d;
    logic [15:0]     err_q, err_d;
    logic [15:0]     tog_q, tog_d;
    logic            pass_q, pass_d;
    logic            prev_q, prev_d;
    logic            first_q, first_d;
    logic [LAT-1:0]  vld_q, vld_d;
    logic [LAT-1:0]  exp_q, exp_d;

    logic start_run, run_more, issue, exp_new, cmp_valid, pipe_empty;

    assign start_run  = (state_q == S_IDLE) && bus.START;
    assign run_more   = (state_q == S_RUN) && (issued_q < N_VEC_W);
    assign issue      = start_run || run_more;
    assign cmp_valid  = vld_q[LAT-1];
    assign pipe_empty = (vld_q == '0);

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values.
        if (!RSTB) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: default assignment first, so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.START) state_d = S_RUN;
            S_RUN:   if (!run_more) state_d = S_DRAIN;
            S_DRAIN: if (pipe_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        bus.BUSY = (state_q == S_RUN) || (state_q == S_DRAIN);
        bus.DONE = (state_q == S_DONE);
    end

    assign bus.STIM    = stim_q;
    assign bus.PASS    = pass_q;
    assign bus.ERR_CNT = err_q;
    assign bus.TOG_CNT = tog_q;

    // ---------------- datapath next state ----------------
    always_comb begin
        stim_d   = stim_q;
        issued_d = issued_q;
        err_d    = err_q;
        tog_d    = tog_q;
        pass_d   = pass_q;
        prev_d   = prev_q;
        first_d  = first_q;

        if (start_run) begin
            stim_d   = SEED_EFF;
            issued_d = 16'd1;
        end else if (run_more) begin
            stim_d   = {stim_q[4:0], stim_q[5] ^ stim_q[4]};
            issued_d = issued_q + 16'd1;
        end

        exp_new = (stim_d[0] | stim_d[1]) & (stim_d[2] | stim_d[3]) & (stim_d[4] | stim_d[5]);
        vld_d   = LAT'({vld_q, issue});
        exp_d   = LAT'({exp_q, exp_new});

        if (start_run) begin
            err_d   = '0;
            tog_d   = '0;
            pass_d  = 1'b0;
            first_d = 1'b1;
        end else begin
            if (cmp_valid) begin
                if ((bus.DUT_Q != exp_q[LAT-1]) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
                if (!first_q && (bus.DUT_Q != prev_q) && (tog_q != 16'hFFFF)) tog_d = tog_q + 16'd1;
                prev_d  = bus.DUT_Q;
                first_d = 1'b0;
            end
            // PASS is latched on the edge that enters DONE, after the last comparison has retired.
            if ((state_q == S_DRAIN) && pipe_empty) pass_d = (err_q == 16'd0);
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            stim_q   <= 6'h00;
            issued_q <= '0;
            err_q    <= '0;
            tog_q    <= '0;
            pass_q   <= 1'b0;
            prev_q   <= 1'b0;
            first_q  <= 1'b1;
            vld_q    <= '0;
        end else begin
            stim_q   <= stim_d;
            issued_q <= issued_d;
            err_q    <= err_d;
            tog_q    <= tog_d;
            pass_q   <= pass_d;
            prev_q   <= prev_d;
            first_q  <= first_d;
            vld_q    <= vld_d;
        end
    end

    // NOTE: the expected-value pipeline is not reset, because vld_q gates every use of it.
    always_ff @(posedge CLK) begin
        exp_q <= exp_d;
    end
endmodule

// File: tb/tb_oa222_stim_checker.sv
// Directed bench: five checker instances, each with a different configuration and a different model of the cell.
module tb_oa222_stim_checker;
    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       rstb_e = 1'b0;
    logic       inv_a = 1'b0;
    logic [5:0] stim_c_d1 = 6'h00;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    function automatic logic oa222(input logic [5:0] s);
        return (s[0] | s[1]) & (s[2] | s[3]) & (s[4] | s[5]);
    endfunction

    function automatic logic [5:0] lfsr(input logic [5:0] s);
        return {s[4:0], s[5] ^ s[4]};
    endfunction

    oa222_stim_checker_if if_a ();
    oa222_stim_checker_if if_b ();
    oa222_stim_checker_if if_c ();
    oa222_stim_checker_if if_d ();
    oa222_stim_checker_if if_e ();

    // Cell models: golden or inverted (a), stuck at 0 (b, d), golden with one register stage (c), golden (e).
    assign if_a.DUT_Q = inv_a ^ oa222(if_a.STIM);
    assign if_b.DUT_Q = 1'b0;
    always @(posedge clk) stim_c_d1 <= if_c.STIM;
    assign if_c.DUT_Q = oa222(stim_c_d1);
    assign if_d.DUT_Q = 1'b0;
    assign if_e.DUT_Q = oa222(if_e.STIM);

    oa222_stim_checker #(.N_VEC(2),  .LAT(1))                u_a (.CLK(clk), .RSTB(rstb),   .bus(if_a));
    oa222_stim_checker #(.N_VEC(1),  .LAT(1))                u_b (.CLK(clk), .RSTB(rstb),   .bus(if_b));
    oa222_stim_checker #(.N_VEC(63), .LAT(2))                u_c (.CLK(clk), .RSTB(rstb),   .bus(if_c));
    oa222_stim_checker #(.N_VEC(1),  .LAT(1), .SEED(6'h00))  u_d (.CLK(clk), .RSTB(rstb),   .bus(if_d));
    oa222_stim_checker #(.N_VEC(20), .LAT(1))                u_e (.CLK(clk), .RSTB(rstb_e), .bus(if_e));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  v;
        logic [63:0] seen;
        logic        prev_exp;
        int          n;
        int          dones;
        int          exp_tog;

        if_a.START = 1'b0;
        if_b.START = 1'b0;
        if_c.START = 1'b0;
        if_d.START = 1'b0;
        if_e.START = 1'b0;
        step();
        step();
        rstb   = 1'b1;
        rstb_e = 1'b1;

        check("rst_stim", if_a.STIM, 6'h00);
        check("rst_busy", if_a.BUSY, 1'b0);
        check("rst_done", if_a.DONE, 1'b0);
        check("rst_pass", if_a.PASS, 1'b0);
        check("rst_err",  if_a.ERR_CNT, 16'd0);
        check("rst_tog",  if_a.TOG_CNT, 16'd0);

        // Run A1: golden cell, N_VEC=2, LAT=1.
        if_a.START = 1'b1;
        step();
        if_a.START = 1'b0;
        check("a_stim0", if_a.STIM, 6'h2D);
        check("a_busy0", if_a.BUSY, 1'b1);
        step();
        check("a_stim1", if_a.STIM, 6'h1B);
        step();
        check("a_done_early", if_a.DONE, 1'b0);
        check("a_busy_drain", if_a.BUSY, 1'b1);
        step();
        check("a_done",      if_a.DONE, 1'b1);
        check("a_pass",      if_a.PASS, 1'b1);
        check("a_err",       if_a.ERR_CNT, 16'd0);
        check("a_tog",       if_a.TOG_CNT, 16'd0);
        check("a_busy_done", if_a.BUSY, 1'b0);
        step();
        check("a_done_pulse", if_a.DONE, 1'b0);
        check("a_stim_hold",  if_a.STIM, 6'h1B);
        check("a_pass_hold",  if_a.PASS, 1'b1);

        // Run A2: inverted cell, and a second START while BUSY.
        inv_a = 1'b1;
        if_a.START = 1'b1;
        step();
        step();
        if_a.START = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (if_a.DONE) dones++;
        end
        check("a2_one_done", dones, 1);
        check("a2_idle",     if_a.BUSY, 1'b0);
        check("a2_err",      if_a.ERR_CNT, 16'd2);
        check("a2_pass",     if_a.PASS, 1'b0);

        // Run A3: START held high, so a new run begins once the block is back in IDLE.
        inv_a = 1'b0;
        if_a.START = 1'b1;
        step();
        step();
        step();
        step();
        check("a3_done",      if_a.DONE, 1'b1);
        check("a3_pass_inv",  if_a.PASS, 1'b1);
        step();
        check("a3_idle_gap",  if_a.BUSY, 1'b0);
        step();
        check("a3_restart",   if_a.BUSY, 1'b1);
        check("a3_stim",      if_a.STIM, 6'h2D);
        if_a.START = 1'b0;
        for (n = 0; n < 10 && !if_a.DONE; n++) step();
        check("a3_done2", if_a.DONE, 1'b1);

        // Run B: cell stuck at 0 with N_VEC=1. Vector 2D gives EXP=1, so one mismatch.
        if_b.START = 1'b1;
        step();
        if_b.START = 1'b0;
        check("b_stim", if_b.STIM, 6'h2D);
        step();
        step();
        check("b_done", if_b.DONE, 1'b1);
        check("b_err",  if_b.ERR_CNT, 16'd1);
        check("b_pass", if_b.PASS, 1'b0);
        check("b_tog",  if_b.TOG_CNT, 16'd0);

        // Run C: full LFSR period, LAT=2, registered golden cell.
        v = 6'h2D;
        seen = '0;
        exp_tog = 0;
        prev_exp = 1'b0;
        if_c.START = 1'b1;
        step();
        if_c.START = 1'b0;
        for (int k = 0; k < 63; k++) begin
            check($sformatf("c_stim%0d", k), if_c.STIM, v);
            seen[if_c.STIM] = 1'b1;
            if (k > 0 && oa222(v) != prev_exp) exp_tog++;
            prev_exp = oa222(v);
            v = lfsr(v);
            if (k < 62) step();
        end
        n = 62;
        while (!if_c.DONE && n < 200) begin
            step();
            n++;
        end
        check("c_done_edge", n, 65);
        check("c_no_zero",   seen[0], 1'b0);
        check("c_distinct",  $countones(seen), 63);
        check("c_pass",      if_c.PASS, 1'b1);
        check("c_err",       if_c.ERR_CNT, 16'd0);
        check("c_tog",       if_c.TOG_CNT, exp_tog);

        // Run D: zero seed is replaced by 01. EXP(01)=0 matches the stuck-at-0 cell.
        if_d.START = 1'b1;
        step();
        if_d.START = 1'b0;
        check("d_stim", if_d.STIM, 6'h01);
        step();
        step();
        check("d_done", if_d.DONE, 1'b1);
        check("d_pass", if_d.PASS, 1'b1);
        check("d_err",  if_d.ERR_CNT, 16'd0);

        // Run E: reset asserted on the edge where issued==10.
        if_e.START = 1'b1;
        step();
        if_e.START = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("e_busy_pre", if_e.BUSY, 1'b1);
        rstb_e = 1'b0;
        step();
        rstb_e = 1'b1;
        check("e_stim", if_e.STIM, 6'h00);
        check("e_busy", if_e.BUSY, 1'b0);
        check("e_err",  if_e.ERR_CNT, 16'd0);
        check("e_tog",  if_e.TOG_CNT, 16'd0);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            if (if_e.DONE) dones++;
            step();
        end
        check("e_no_done", dones, 0);

        // Reset takes priority over START on the same edge.
        if_e.START = 1'b1;
        rstb_e = 1'b0;
        step();
        rstb_e = 1'b1;
        if_e.START = 1'b0;
        check("e_prio_busy", if_e.BUSY, 1'b0);
        check("e_prio_stim", if_e.STIM, 6'h00);
        step();
        check("e_prio_idle", if_e.BUSY, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
